// File: rtl/stack_mem_ctrl.sv
// stack_mem_ctrl
// Sequences push/pop traffic between the stack-machine controller and a
// single-port synchronous stack RAM. Owns the stack pointer (count) and the
// occupancy flags, and returns popped data with a one-cycle valid pulse.
//
// Build option: define STACK_PEEK_EN to add the req_peek input, a
// non-destructive read of the top-of-stack word.
module stack_mem_ctrl #(
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_push,
  input  logic          req_pop,
  input  logic [DW-1:0] push_data,
  output logic          req_ready,
  output logic [DW-1:0] pop_data,
  output logic          pop_valid,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          ovf_err,
  output logic          unf_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
`ifdef STACK_PEEK_EN
  ,
  input  logic          req_peek
`endif
);

  localparam int unsigned LCW      = $clog2(MEM_LAT + 1);
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, DONE} state_t;

  state_t          state_q,     state_d;
  logic [AW:0]     count_q,     count_d;
  logic [DW-1:0]   pop_data_q,  pop_data_d;
  logic            pop_valid_q, pop_valid_d;
  logic            ovf_q,       ovf_d;
  logic            unf_q,       unf_d;
  logic [AW-1:0]   mem_addr_q,  mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_we_q,    mem_we_d;
  logic            mem_re_q,    mem_re_d;
  logic [LCW-1:0]  wait_cnt_q,  wait_cnt_d;
  logic            dec_q,       dec_d;

  logic            is_empty;
  logic            is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);

  // Next-state and next-output decode for the request sequencer
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    ovf_d       = 1'b0;
    unf_d       = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    dec_d       = dec_q;

    unique case (state_q)
      IDLE: begin
        if (req_push) begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            state_d     = WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = count_q[AW-1:0];
            mem_wdata_d = push_data;
          end
        end else if (req_pop) begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            state_d    = READ;
            mem_re_d   = 1'b1;
            mem_addr_d = count_q[AW-1:0] - AW'(1);
            dec_d      = 1'b1;
          end
        end
`ifdef STACK_PEEK_EN
        else if (req_peek) begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            state_d    = READ;
            mem_re_d   = 1'b1;
            mem_addr_d = count_q[AW-1:0] - AW'(1);
            dec_d      = 1'b0;
          end
        end
`endif
      end

      WRITE: begin
        count_d = count_q + (AW+1)'(1);
        state_d = IDLE;
      end

      // mem_re is itself registered, so read data is first valid MEM_LAT
      // cycles after READ ends; WAIT therefore spans MEM_LAT cycles and the
      // capture happens on its last one.
      READ: begin
        if (dec_q) begin
          count_d = count_q - (AW+1)'(1);
        end
        wait_cnt_d = LCW'(MEM_LAT - 1);
        state_d    = WAIT;
      end

      WAIT: begin
        if (wait_cnt_q == '0) begin
          pop_data_d  = mem_rdata;
          pop_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - LCW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      wait_cnt_q  <= '0;
      dec_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      wait_cnt_q  <= wait_cnt_d;
      dec_q       <= dec_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Directed bench for stack_mem_ctrl: one instance with MEM_LAT=1 and one
// with MEM_LAT=3, each backed by a behavioural RAM of matching latency.
module tb_stack_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance with MEM_LAT=1
  logic       req_push = 1'b0, req_pop = 1'b0, req_peek = 1'b0;
  logic [7:0] push_data = '0;
  logic       req_ready, pop_valid, empty, full, ovf_err, unf_err, mem_we, mem_re;
  logic [7:0] pop_data, mem_wdata, mem_rdata;
  logic [5:0] count;
  logic [4:0] mem_addr;

  stack_mem_ctrl #(.AW(5), .DW(8), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_push(req_push), .req_pop(req_pop),
    .push_data(push_data), .req_ready(req_ready), .pop_data(pop_data),
    .pop_valid(pop_valid), .count(count), .empty(empty), .full(full),
    .ovf_err(ovf_err), .unf_err(unf_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
`ifdef STACK_PEEK_EN
    , .req_peek(req_peek)
`endif
  );

  // Instance with MEM_LAT=3
  logic       push_3 = 1'b0, pop_3 = 1'b0, peek_3 = 1'b0;
  logic [7:0] pdata_3 = '0;
  logic       ready_3, pv_3, empty_3, full_3, ovf_3, unf_3, we_3, re_3;
  logic [7:0] popd_3, wdata_3, rdata_3;
  logic [5:0] cnt_3;
  logic [4:0] addr_3;

  stack_mem_ctrl #(.AW(5), .DW(8), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_push(push_3), .req_pop(pop_3),
    .push_data(pdata_3), .req_ready(ready_3), .pop_data(popd_3),
    .pop_valid(pv_3), .count(cnt_3), .empty(empty_3), .full(full_3),
    .ovf_err(ovf_3), .unf_err(unf_3), .mem_addr(addr_3),
    .mem_wdata(wdata_3), .mem_we(we_3), .mem_re(re_3),
    .mem_rdata(rdata_3)
`ifdef STACK_PEEK_EN
    , .req_peek(peek_3)
`endif
  );

  // RAM models: data is valid only in the single cycle MEM_LAT after mem_re,
  // otherwise the read port shows 8'hEE, so an early or late capture is visible.
  logic [7:0] ram1 [0:31];
  logic [7:0] rd1 = 8'hEE;
  always @(posedge clk) begin
    if (mem_we) ram1[mem_addr] <= mem_wdata;
    rd1 <= mem_re ? ram1[mem_addr] : 8'hEE;
  end
  assign mem_rdata = rd1;

  logic [7:0] ram3 [0:31];
  logic [7:0] p3a = 8'hEE, p3b = 8'hEE, rd3 = 8'hEE;
  always @(posedge clk) begin
    if (we_3) ram3[addr_3] <= wdata_3;
    p3a <= re_3 ? ram3[addr_3] : 8'hEE;
    p3b <= p3a;
    rd3 <= p3b;
  end
  assign rdata_3 = rd3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] d);
    req_push  = 1'b1;
    push_data = d;
    tick();
    req_push  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    total++;
    if ({req_ready, empty, full, pop_valid, ovf_err, unf_err, mem_we, mem_re} !== 8'b1100_0000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=11000000",
               {req_ready, empty, full, pop_valid, ovf_err, unf_err, mem_we, mem_re});
    end
    total++;
    if ({count, mem_addr, mem_wdata, pop_data} !== 27'd0) begin
      bad++;
      $display("FAIL reset_values count=%0d addr=%0d wdata=%h pop_data=%h exp all 0",
               count, mem_addr, mem_wdata, pop_data);
    end
    total++;
    if ({ready_3, empty_3, cnt_3} !== {2'b11, 6'd0}) begin
      bad++;
      $display("FAIL reset_dut3 got ready=%b empty=%b count=%0d exp 1 1 0", ready_3, empty_3, cnt_3);
    end
  endtask

  task automatic test_push();
    logic [7:0] vals [2];
    vals[0] = 8'hA5;
    vals[1] = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      req_push  = 1'b1;
      push_data = vals[i];
      tick();
      req_push  = 1'b0;
      total++;
      if ({mem_we, mem_addr, mem_wdata, req_ready} !== {1'b1, 5'(i), vals[i], 1'b0}) begin
        bad++;
        $display("FAIL push_write%0d got we=%b addr=%0d wdata=%h ready=%b exp 1 %0d %h 0",
                 i, mem_we, mem_addr, mem_wdata, req_ready, i, vals[i]);
      end
      tick();
      total++;
      if ({req_ready, mem_we, count} !== {2'b10, 6'(i + 1)}) begin
        bad++;
        $display("FAIL push_done%0d got ready=%b we=%b count=%0d exp 1 0 %0d",
                 i, req_ready, mem_we, count, i + 1);
      end
    end
    total++;
    if ({empty, full} !== 2'b00) begin
      bad++;
      $display("FAIL push_flags got empty=%b full=%b exp 0 0", empty, full);
    end
  endtask

  task automatic test_pop();
    logic [7:0] exp_d [2];
    int n;
    exp_d[0] = 8'h3C;
    exp_d[1] = 8'hA5;
    for (int i = 0; i < 2; i++) begin
      req_pop = 1'b1;
      tick();
      req_pop = 1'b0;
      total++;
      if ({mem_re, mem_we, mem_addr} !== {2'b10, 5'(1 - i)}) begin
        bad++;
        $display("FAIL pop_read%0d got re=%b we=%b addr=%0d exp 1 0 %0d", i, mem_re, mem_we, mem_addr, 1 - i);
      end
      n = 0;
      while (pop_valid !== 1'b1 && n < 12) begin
        tick();
        n++;
      end
      total++;
      if (n !== 2) begin
        bad++;
        $display("FAIL pop_latency%0d got %0d edges exp 2", i, n);
      end
      total++;
      if ({pop_data, count} !== {exp_d[i], 6'(1 - i)}) begin
        bad++;
        $display("FAIL pop_data%0d got data=%h count=%0d exp %h %0d", i, pop_data, count, exp_d[i], 1 - i);
      end
      tick();
      total++;
      if ({pop_valid, req_ready, pop_data} !== {2'b01, exp_d[i]}) begin
        bad++;
        $display("FAIL pop_after%0d got valid=%b ready=%b data=%h exp 0 1 %h",
                 i, pop_valid, req_ready, pop_data, exp_d[i]);
      end
    end
    total++;
    if ({empty, count} !== {1'b1, 6'd0}) begin
      bad++;
      $display("FAIL pop_empty got empty=%b count=%0d exp 1 0", empty, count);
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] d;
    int n;
    for (int i = 0; i < 32; i++) begin
      d = 8'(8'h40 + 3 * i);
      req_push  = 1'b1;
      push_data = d;
      tick();
      req_push  = 1'b0;
      total++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 5'(i), d}) begin
        bad++;
        $display("FAIL fill_write%0d got we=%b addr=%0d wdata=%h exp 1 %0d %h", i, mem_we, mem_addr, mem_wdata, i, d);
      end
      tick();
    end
    total++;
    if ({full, empty, count} !== {2'b10, 6'd32}) begin
      bad++;
      $display("FAIL fill_full got full=%b empty=%b count=%0d exp 1 0 32", full, empty, count);
    end
    req_push  = 1'b1;
    push_data = 8'hFF;
    tick();
    req_push  = 1'b0;
    total++;
    if ({ovf_err, mem_we, req_ready} !== 3'b101) begin
      bad++;
      $display("FAIL ovf_pulse got ovf=%b we=%b ready=%b exp 1 0 1", ovf_err, mem_we, req_ready);
    end
    tick();
    total++;
    if ({ovf_err, mem_we, count} !== {2'b00, 6'd32}) begin
      bad++;
      $display("FAIL ovf_after got ovf=%b we=%b count=%0d exp 0 0 32", ovf_err, mem_we, count);
    end
    // drain and confirm LIFO order
    for (int i = 31; i >= 0; i--) begin
      d = 8'(8'h40 + 3 * i);
      req_pop = 1'b1;
      tick();
      req_pop = 1'b0;
      n = 0;
      while (pop_valid !== 1'b1 && n < 12) begin
        tick();
        n++;
      end
      total++;
      if (pop_data !== d || n !== 2) begin
        bad++;
        $display("FAIL drain%0d got data=%h edges=%0d exp %h 2", i, pop_data, n, d);
      end
      tick();
    end
    total++;
    if ({empty, count} !== {1'b1, 6'd0}) begin
      bad++;
      $display("FAIL drain_empty got empty=%b count=%0d exp 1 0", empty, count);
    end
  endtask

  task automatic test_underflow();
    req_pop = 1'b1;
    tick();
    req_pop = 1'b0;
    total++;
    if ({unf_err, mem_re, req_ready} !== 3'b101) begin
      bad++;
      $display("FAIL unf_pulse got unf=%b re=%b ready=%b exp 1 0 1", unf_err, mem_re, req_ready);
    end
    tick();
    total++;
    if ({unf_err, mem_re, req_ready, count} !== {3'b001, 6'd0}) begin
      bad++;
      $display("FAIL unf_after got unf=%b re=%b ready=%b count=%0d exp 0 0 1 0", unf_err, mem_re, req_ready, count);
    end
  endtask

  task automatic test_priority();
    int n;
    do_push(8'h11);
    req_push  = 1'b1;
    req_pop   = 1'b1;
    push_data = 8'h77;
    tick();
    req_push  = 1'b0;
    total++;
    if ({mem_we, mem_re, mem_addr, mem_wdata} !== {2'b10, 5'd1, 8'h77}) begin
      bad++;
      $display("FAIL prio_push got we=%b re=%b addr=%0d wdata=%h exp 1 0 1 77", mem_we, mem_re, mem_addr, mem_wdata);
    end
    tick();
    total++;
    if ({count, req_ready} !== {6'd2, 1'b1}) begin
      bad++;
      $display("FAIL prio_count got count=%0d ready=%b exp 2 1", count, req_ready);
    end
    tick();
    req_pop = 1'b0;
    total++;
    if ({mem_re, mem_addr} !== {1'b1, 5'd1}) begin
      bad++;
      $display("FAIL prio_pop got re=%b addr=%0d exp 1 1", mem_re, mem_addr);
    end
    n = 0;
    while (pop_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    total++;
    if ({pop_data, count} !== {8'h77, 6'd1} || n !== 2) begin
      bad++;
      $display("FAIL prio_data got data=%h count=%0d edges=%0d exp 77 1 2", pop_data, count, n);
    end
    tick();
  endtask

`ifdef STACK_PEEK_EN
  task automatic test_peek();
    int n;
    req_peek = 1'b1;
    tick();
    req_peek = 1'b0;
    total++;
    if ({mem_re, mem_addr} !== {1'b1, 5'd0}) begin
      bad++;
      $display("FAIL peek_read got re=%b addr=%0d exp 1 0", mem_re, mem_addr);
    end
    n = 0;
    while (pop_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    total++;
    if ({pop_data, count} !== {8'h11, 6'd1} || n !== 2) begin
      bad++;
      $display("FAIL peek_data got data=%h count=%0d edges=%0d exp 11 1 2", pop_data, count, n);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid_read();
    logic seen;
    req_pop = 1'b1;
    tick();
    req_pop = 1'b0;
    total++;
    if (mem_re !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_read got re=%b exp 1", mem_re);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({mem_re, mem_we, pop_valid, req_ready, count, mem_addr, pop_data} !== {4'b0001, 6'd0, 5'd0, 8'd0}) begin
      bad++;
      $display("FAIL rstmid_async got re=%b we=%b valid=%b ready=%b count=%0d addr=%0d data=%h exp 0 0 0 1 0 0 00",
               mem_re, mem_we, pop_valid, req_ready, count, mem_addr, pop_data);
    end
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (pop_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if ({seen, count, req_ready} !== {1'b0, 6'd0, 1'b1}) begin
      bad++;
      $display("FAIL rstmid_after got seen_valid=%b count=%0d ready=%b exp 0 0 1", seen, count, req_ready);
    end
  endtask

  task automatic test_latency3();
    logic [7:0] exp_d [2];
    int n;
    pdata_3 = 8'h5A; push_3 = 1'b1; tick(); push_3 = 1'b0; tick();
    pdata_3 = 8'hC3; push_3 = 1'b1; tick(); push_3 = 1'b0; tick();
    total++;
    if (cnt_3 !== 6'd2) begin
      bad++;
      $display("FAIL lat3_count got %0d exp 2", cnt_3);
    end
    exp_d[0] = 8'hC3;
    exp_d[1] = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      pop_3 = 1'b1;
      tick();
      pop_3 = 1'b0;
      n = 0;
      while (pv_3 !== 1'b1 && n < 16) begin
        tick();
        n++;
      end
      total++;
      if (n !== 4) begin
        bad++;
        $display("FAIL lat3_latency%0d got %0d edges exp 4", i, n);
      end
      total++;
      if ({popd_3, cnt_3} !== {exp_d[i], 6'(1 - i)}) begin
        bad++;
        $display("FAIL lat3_data%0d got data=%h count=%0d exp %h %0d", i, popd_3, cnt_3, exp_d[i], 1 - i);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop();
    test_fill_overflow();
    test_underflow();
    test_priority();
`ifdef STACK_PEEK_EN
    test_peek();
`endif
    test_reset_mid_read();
    test_latency3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
